if_fetch: RTL and testbench

Instruction fetch unit for the tinyrisc core: owns the program counter, issues word reads on the instruction bus, buffers returned words in a small flushable FIFO and presents `inst_o`/`inst_addr_o` to the decode stage. Redirects from the execute stage (`jump_flag_i`/`jump_addr_i`) flush the buffer and discard in-flight responses. It sits between the instruction memory port and `id`, and is the producer of the decode stage's `inst_i`/`inst_addr_i` inputs.

---
 rtl/if_fetch_pkg.sv | 24 ++
 rtl/if_fifo.sv | 82 ++++++++
 rtl/if_fetch.sv | 131 +++++++++++++
 tb/tb_if_fetch.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the tinyrisc instruction fetch unit.
// Build option: IF_BUS_ERR_EN (macro). When defined, every fetched entry also
// carries the bus error bit and the fetch unit grows ibus_err_i/inst_err_o.
package if_fetch_pkg;

    localparam logic [31:0] INST_NOP           = 32'h0000_0013;
    localparam logic [31:0] ZeroWord           = 32'h0000_0000;
    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

    // Fetch FSM encodings
    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    // One buffered instruction: the returned word and the address it came from
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
`ifdef IF_BUS_ERR_EN
        logic        err;
`endif
    } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Instruction buffer for if_fetch. A pending-tag queue remembers the address
// of every granted read; each accepted response pops the oldest tag and is
// stored together with it. Flush is synchronous and empties both queues.
// Build option: IF_BUS_ERR_EN adds a stored error bit per entry.
module if_fifo
    import if_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          tag_push,
    input  logic [31:0]   tag_addr,
    input  logic          resp_valid,
    input  logic [31:0]   resp_data,
`ifdef IF_BUS_ERR_EN
    input  logic          resp_err,
`endif
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t  data_mem [DEPTH];
    logic [31:0]   tag_mem  [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] tag_wr;
    logic [AW-1:0] tag_rd;
    logic          pop_ok;
    logic          push_ok;
    fetch_entry_t  new_entry;

    // Simultaneous push and pop is allowed even when full
    assign pop_ok  = pop & (count != '0);
    assign push_ok = resp_valid & ((count != CW'(DEPTH)) | pop_ok);

    assign new_entry.instr = resp_data;
    assign new_entry.addr  = tag_mem[tag_rd];
`ifdef IF_BUS_ERR_EN
    assign new_entry.err   = resp_err;
`endif

    assign head = data_mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush wins over push and pop
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            tag_wr <= '0;
            tag_rd <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            tag_wr <= '0;
            tag_rd <= '0;
            count  <= '0;
        end else begin
            if (tag_push)   tag_wr <= tag_wr + AW'(1);
            if (resp_valid) tag_rd <= tag_rd + AW'(1);
            if (push_ok)    wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)     rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage writes for tags and buffered entries
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are deliberately not reset; the pointers and
        // count alone decide which slots hold live data.
        if (tag_push) tag_mem[tag_wr]  <= tag_addr;
        if (push_ok)  data_mem[wr_ptr] <= new_entry;
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch unit for the tinyrisc core: owns the PC, issues word
// reads, buffers responses in if_fifo and feeds the decode stage. A jump
// flushes the buffer; responses still in flight are counted and dropped.
// Build option: IF_BUS_ERR_EN adds ibus_err_i and inst_err_o.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
`ifdef IF_BUS_ERR_EN
    input  logic        ibus_err_i,
    output logic        inst_err_o,
`endif
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] discard_nxt;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    logic          grant;
    logic          resp_drop;
    logic          resp_accept;
    logic          pop;
    fetch_entry_t  head;
    logic          unused_bits;

    // Word alignment ignores the low target bits
    assign unused_bits = &{1'b0, jump_addr_i[1:0]};

    // In-flight reads plus buffered words may never exceed the buffer size,
    // so every granted read already owns a slot when its data returns
    assign occupancy   = {1'b0, outstanding} + {1'b0, fifo_count};
    assign ibus_req_o  = (state == FETCH) & ~jump_flag_i
                       & (occupancy < (CW + 1)'(FIFO_DEPTH));
    assign ibus_addr_o = fetch_pc;
    assign grant       = ibus_req_o & ibus_gnt_i;

    assign resp_drop   = ibus_rvalid_i & (discard_cnt != '0);
    assign resp_accept = ibus_rvalid_i & (discard_cnt == '0);

    assign inst_valid_o = (fifo_count != '0) & ~jump_flag_i;
    assign pop          = inst_valid_o & ~hold_flag_i;
    assign inst_o       = inst_valid_o ? head.instr : INST_NOP;
    assign inst_addr_o  = inst_valid_o ? head.addr  : ZeroWord;
`ifdef IF_BUS_ERR_EN
    assign inst_err_o   = inst_valid_o & head.err;
`endif

    assign outstanding_nxt = outstanding + CW'(grant) - CW'(ibus_rvalid_i);

    // Discard count: reloaded with every read still in flight on a jump
    always_comb begin
        // NOTE: default assignment first so no path leaves the value held,
        // which would otherwise infer a latch.
        discard_nxt = discard_cnt;
        if (jump_flag_i) begin
            discard_nxt = outstanding_nxt;
        end else if (resp_drop) begin
            discard_nxt = discard_cnt - CW'(1);
        end
    end

    // Next state: drain while stale reads remain, fetch otherwise
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:         state_nxt = FETCH;
            FETCH, DRAIN: state_nxt = (discard_nxt != '0) ? DRAIN : FETCH;
            default:      state_nxt = BOOT;
        endcase
    end

    // FSM, program counter and read counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT;
            fetch_pc    <= RESET_ADDR;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding_nxt;
            discard_cnt <= discard_nxt;
            if (jump_flag_i) begin
                fetch_pc <= {jump_addr_i[31:2], 2'b00};
            end else if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    if_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (jump_flag_i),
        .tag_push   (grant),
        .tag_addr   (fetch_pc),
        .resp_valid (resp_accept),
        .resp_data  (ibus_rdata_i),
`ifdef IF_BUS_ERR_EN
        .resp_err   (ibus_err_i),
`endif
        .pop        (pop),
        .head       (head),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a behavioural memory with random grant
// and response latency, and a reference model that tracks the expected
// instruction stream, the expected fetch address and bus occupancy.
`timescale 1ns/1ps
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        hold_flag_i = 1'b0;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i = 1'b0;
    logic        ibus_rvalid_i = 1'b0;
    logic [31:0] ibus_rdata_i = '0;
`ifdef IF_BUS_ERR_EN
    logic        ibus_err_i = 1'b0;
    logic        inst_err_o;
`endif
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    always #5 clk = ~clk;

    if_fetch #(
        .RESET_ADDR (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .hold_flag_i   (hold_flag_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
`ifdef IF_BUS_ERR_EN
        .ibus_err_i    (ibus_err_i),
        .inst_err_o    (inst_err_o),
`endif
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          cyc;
    } rd_t;

    rd_t         pend[$];
    int          epoch       = 0;
    int          buffered    = 0;
    int          cyc         = 0;
    int          first_valid = -1;
    logic [31:0] exp_addr    = '0;
    logic [31:0] exp_fetch   = '0;
    logic        prev_req    = 1'b0;
    logic        prev_gnt    = 1'b0;
    logic [31:0] prev_addr   = '0;
    logic        last_req    = 1'b0;
    logic [31:0] jf_inst     = '0;
    bit          jf_seen     = 1'b0;
    logic [31:0] jf_grant    = '0;
    bit          jg_seen     = 1'b0;

    // Stimulus knobs
    logic        k_gnt = 1'b0;
    logic        k_rv = 1'b0;
    logic        k_hold = 1'b0;
    logic        k_jump = 1'b0;
    logic [31:0] k_jaddr = '0;

    task automatic observe(input logic rv);
        int   stale;
        logic exp_valid;
        logic exp_req;
        stale = 0;
        foreach (pend[i]) if (pend[i].epoch != epoch) stale++;
        exp_valid = (buffered > 0) && !jump_flag_i;
        exp_req   = (cyc >= 1) && !jump_flag_i && (stale == 0)
                  && ((pend.size() + buffered) < DEPTH);

        // Decode-side view
        check("inst_valid", 32'(inst_valid_o), 32'(exp_valid));
        if (inst_valid_o) begin
            if (first_valid < 0) first_valid = cyc;
            if (!jf_seen) begin
                jf_inst = inst_addr_o;
                jf_seen = 1'b1;
            end
            check("head_addr", inst_addr_o, exp_addr);
            check("head_inst", inst_o, exp_addr ^ KEY);
`ifdef IF_BUS_ERR_EN
            check("head_err", 32'(inst_err_o), 32'(exp_addr == 32'h4));
`endif
            if (!hold_flag_i) begin
                exp_addr += 32'd4;
                buffered--;
            end
        end else begin
            check("idle_inst", inst_o, INST_NOP);
            check("idle_addr", inst_addr_o, ZeroWord);
        end

        // Bus-side view
        check("ibus_req", 32'(ibus_req_o), 32'(exp_req));
        if (prev_req && !prev_gnt && !jump_flag_i)
            check("addr_stable", ibus_addr_o, prev_addr);
        if (ibus_req_o)
            check("req_addr", ibus_addr_o, exp_fetch);

        if (rv) begin
            if (pend[0].epoch == epoch && !jump_flag_i) buffered++;
            void'(pend.pop_front());
        end
        if (ibus_req_o && ibus_gnt_i) begin
            if (!jg_seen) begin
                jf_grant = ibus_addr_o;
                jg_seen  = 1'b1;
            end
            pend.push_back('{addr: exp_fetch, epoch: epoch, cyc: cyc});
            exp_fetch += 32'd4;
        end
        if (jump_flag_i) begin
            epoch++;
            buffered  = 0;
            exp_addr  = {jump_addr_i[31:2], 2'b00};
            exp_fetch = {jump_addr_i[31:2], 2'b00};
            jf_seen   = 1'b0;
            jg_seen   = 1'b0;
        end
        prev_req  = ibus_req_o;
        prev_gnt  = ibus_gnt_i;
        prev_addr = ibus_addr_o;
        last_req  = ibus_req_o;
    endtask

    // One cycle: drive inputs just after the edge, sample at the falling edge
    task automatic tick();
        logic rv;
        rv = k_rv && (pend.size() > 0) && (pend[0].cyc < cyc);
        ibus_gnt_i    = k_gnt;
        ibus_rvalid_i = rv;
        ibus_rdata_i  = rv ? (pend[0].addr ^ KEY) : 32'h0;
`ifdef IF_BUS_ERR_EN
        ibus_err_i    = rv && (pend[0].addr == 32'h4);
`endif
        hold_flag_i   = k_hold;
        jump_flag_i   = k_jump;
        jump_addr_i   = k_jaddr;
        @(negedge clk);
        observe(rv);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_two_outstanding(input string tag);
        for (int i = 0; i < 20 && !(pend.size() == 2 && buffered == 0); i++) tick();
        check(tag, 32'(pend.size()), 32'd2);
    endtask

    task automatic jump_to(input logic [31:0] target);
        k_jump  = 1'b1;
        k_jaddr = target;
        tick();
        k_jump  = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req",   32'(ibus_req_o), 32'd0);
        check("rst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_inst",  inst_o, INST_NOP);
        check("rst_addr",  inst_addr_o, ZeroWord);
        check("rst_state", 32'(dut.state), 32'(BOOT));
        check("rst_pc",    ibus_addr_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;

        // Streaming with single-cycle memory
        k_gnt = 1'b1;
        k_rv  = 1'b1;
        repeat (12) tick();
        check("first_valid_cycle", 32'(first_valid), 32'd3);

        // Decode stall fills the buffer and stops requests
        k_hold = 1'b1;
        repeat (5) tick();
        check("hold_req_low", 32'(last_req), 32'd0);
        k_hold = 1'b0;
        repeat (8) tick();

        // Jump with two reads in flight
        k_rv = 1'b0;
        wait_two_outstanding("wait_out_a");
        jump_to(32'h0000_0103);
        check("drain_state_a", 32'(dut.state), 32'(DRAIN));
        k_rv = 1'b1;
        repeat (10) tick();
        check("jump_grant_a", jf_grant, 32'h0000_0100);
        check("jump_inst_a",  jf_inst,  32'h0000_0100);

        // Second jump while still draining
        k_rv = 1'b0;
        wait_two_outstanding("wait_out_b");
        jump_to(32'h0000_0200);
        k_rv = 1'b1;
        tick();
        k_rv = 1'b0;
        jump_to(32'h0000_0300);
        check("drain_state_b", 32'(dut.state), 32'(DRAIN));
        k_rv = 1'b1;
        repeat (10) tick();
        check("jump_grant_b", jf_grant, 32'h0000_0300);
        check("jump_inst_b",  jf_inst,  32'h0000_0300);

        // Grant withheld: request holds, then a jump withdraws it
        k_gnt = 1'b0;
        repeat (3) tick();
        check("gnt_low_req", 32'(last_req), 32'd1);
        jump_to(32'h0000_0400);
        check("jump_withdraw", 32'(last_req), 32'd0);
        k_gnt = 1'b1;
        repeat (6) tick();
        check("jump_grant_c", jf_grant, 32'h0000_0400);

        // Randomised traffic, including targets near the top of memory
        for (int i = 0; i < 3000; i++) begin
            k_gnt  = ($urandom_range(0, 3) != 0);
            k_rv   = ($urandom_range(0, 2) != 0);
            k_hold = ($urandom_range(0, 3) == 0);
            k_jump = ($urandom_range(0, 24) == 0);
            k_jaddr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F))
                                                   : $urandom;
            tick();
        end
        k_jump = 1'b0;

        // Reset mid-operation clears outputs immediately
        k_gnt = 1'b1;
        k_rv  = 1'b1;
        repeat (6) tick();
        rst = 1'b0;
        ibus_gnt_i    = 1'b0;
        ibus_rvalid_i = 1'b0;
        #2;
        check("mid_rst_req",   32'(ibus_req_o), 32'd0);
        check("mid_rst_valid", 32'(inst_valid_o), 32'd0);
        check("mid_rst_inst",  inst_o, INST_NOP);
        check("mid_rst_addr",  inst_addr_o, ZeroWord);
        check("mid_rst_pc",    ibus_addr_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
